// File: rtl/slip_rx.sv
// rtl/slip_rx.sv - UART 8N1 receiver with SLIP frame decoder
//
// Purpose: receives the host's serial command stream, decodes SLIP framing
// and delivers payload bytes one per strobe, followed by a frame-complete
// strobe carrying the byte count, or a frame-error strobe.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-low reset (0 = reset)
//   i_uart_line  asynchronous UART RX line, idle high
//   o_rx_dv      one-cycle strobe, o_rx_byte holds a decoded payload byte
//   o_rx_byte    decoded byte, held between strobes
//   o_frame_end  one-cycle strobe, a non-empty frame completed
//   o_frame_len  payload byte count, valid with o_frame_end, held
//   o_frame_err  one-cycle strobe, current frame discarded
module slip_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int MAX_LEN      = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_uart_line,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_end,
    output logic [7:0] o_frame_len,
    output logic       o_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // START check lands CLKS_PER_BIT/2 cycles after the first synchronized 0
    // because the counter starts one cycle after that 0 is seen.
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    MAXB = 8'(MAX_LEN);

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    localparam logic [1:0] U_IDLE  = 2'd0;
    localparam logic [1:0] U_START = 2'd1;
    localparam logic [1:0] U_DATA  = 2'd2;
    localparam logic [1:0] U_STOP  = 2'd3;

    localparam logic [1:0] D_DATA = 2'd0;
    localparam logic [1:0] D_ESC  = 2'd1;
    localparam logic [1:0] D_HUNT = 2'd2;

    // ------------------------------------------------------------------
    // Line synchronizer and arming
    // ------------------------------------------------------------------
    logic       sync1;
    logic       sync2;
    logic [1:0] fill;
    logic       armed;

    // fill marks when sync2 holds a real line sample rather than its reset
    // value, so a line that is low when reset releases never arms the UART.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= i_uart_line;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic [1:0]    u_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_stb;
    logic          ferr_stb;

    always_ff @(posedge clk) begin
        if (!reset) begin
            u_state  <= U_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            byte_stb <= 1'b0;
            ferr_stb <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            ferr_stb <= 1'b0;
            case (u_state)
                U_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (armed && !sync2) begin
                        u_state <= U_START;
                    end
                end
                U_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        u_state <= sync2 ? U_IDLE : U_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            u_state <= U_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        byte_stb <= sync2;
                        ferr_stb <= !sync2;
                        u_state  <= U_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: u_state <= U_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SLIP decoder
    // ------------------------------------------------------------------
    logic [1:0] d_state;
    logic [1:0] d_next;
    logic [7:0] count;
    logic       emit;
    logic [7:0] emit_val;
    logic       frame_done;
    logic       frame_bad;
    logic       full;

    assign full = (count == MAXB);

    always_comb begin
        d_next     = d_state;
        emit       = 1'b0;
        emit_val   = shreg;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        if (ferr_stb) begin
            // A hunting decoder has already reported this frame.
            frame_bad = (d_state != D_HUNT);
            d_next    = D_HUNT;
        end else if (byte_stb) begin
            case (d_state)
                D_DATA: begin
                    if (shreg == SLIP_END) begin
                        frame_done = (count != 8'd0);
                    end else if (shreg == SLIP_ESC) begin
                        d_next = D_ESC;
                    end else begin
                        emit = 1'b1;
                    end
                end
                D_ESC: begin
                    d_next = D_DATA;
                    if (shreg == SLIP_ESC_END) begin
                        emit     = 1'b1;
                        emit_val = SLIP_END;
                    end else if (shreg == SLIP_ESC_ESC) begin
                        emit     = 1'b1;
                        emit_val = SLIP_ESC;
                    end else begin
                        frame_bad = 1'b1;
                        d_next    = D_HUNT;
                    end
                end
                D_HUNT: begin
                    if (shreg == SLIP_END) begin
                        d_next = D_DATA;
                    end
                end
                default: d_next = D_HUNT;
            endcase
            // Overlong frame: drop the byte and discard the frame.
            if (emit && full) begin
                emit      = 1'b0;
                frame_bad = 1'b1;
                d_next    = D_HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_state     <= D_DATA;
            count       <= 8'd0;
            o_rx_dv     <= 1'b0;
            o_rx_byte   <= 8'h00;
            o_frame_end <= 1'b0;
            o_frame_len <= 8'h00;
            o_frame_err <= 1'b0;
        end else begin
            d_state     <= d_next;
            o_rx_dv     <= emit;
            o_frame_end <= frame_done;
            o_frame_err <= frame_bad;
            if (emit) begin
                o_rx_byte <= emit_val;
                count     <= count + 8'd1;
            end
            if (frame_done) begin
                o_frame_len <= count;
                count       <= 8'd0;
            end
            // Count stays at zero while hunting so the next frame starts clean.
            if (d_next == D_HUNT) begin
                count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_slip_rx.sv
// tb/tb_slip_rx.sv - scoreboard testbench for slip_rx
module tb_slip_rx;

    localparam int CPB  = 4;
    localparam int MAXL = 3;

    localparam logic [1:0] K_DV  = 2'd0;
    localparam logic [1:0] K_END = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line = 1'b1;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;
    logic       o_frame_end;
    logic [7:0] o_frame_len;
    logic       o_frame_err;

    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [9:0] want;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    slip_rx #(
        .CLKS_PER_BIT(CPB),
        .MAX_LEN     (MAXL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_uart_line(line),
        .o_rx_dv    (o_rx_dv),
        .o_rx_byte  (o_rx_byte),
        .o_frame_end(o_frame_end),
        .o_frame_len(o_frame_len),
        .o_frame_err(o_frame_err)
    );

    // Monitor: pops one expected event per output strobe.
    always @(negedge clk) begin
        if (reset && (o_rx_dv || o_frame_end || o_frame_err)) begin
            checks++;
            if (int'(o_rx_dv) + int'(o_frame_end) + int'(o_frame_err) != 1) begin
                errors++;
                $display("FAIL strobe_excl: dv=%0b end=%0b err=%0b, required exactly one",
                         o_rx_dv, o_frame_end, o_frame_err);
            end
            if (o_rx_dv)          got = {K_DV, o_rx_byte};
            else if (o_frame_end) got = {K_END, o_frame_len};
            else                  got = {K_ERR, 8'h00};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind=%0d val=%02h, required none",
                         got[9:8], got[7:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL event: got kind=%0d val=%02h, required kind=%0d val=%02h",
                             got[9:8], got[7:0], want[9:8], want[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic exp_dv(input logic [7:0] b);
        exp_q.push_back({K_DV, b});
    endtask

    task automatic exp_end(input logic [7:0] n);
        exp_q.push_back({K_END, n});
    endtask

    task automatic exp_err();
        exp_q.push_back({K_ERR, 8'h00});
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
        end
        line = stop;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b1);
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},   int'(o_rx_dv),     0);
        check({tag, "_byte"}, int'(o_rx_byte),   0);
        check({tag, "_end"},  int'(o_frame_end), 0);
        check({tag, "_len"},  int'(o_frame_len), 0);
        check({tag, "_err"},  int'(o_frame_err), 0);
    endtask

    initial begin
        reset = 1'b0;
        line  = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle(10);

        // Basic frame, back-to-back bytes.
        exp_dv(8'h01); exp_dv(8'h02); exp_end(8'd2);
        send(8'hC0); send(8'h01); send(8'h02); send(8'hC0);
        idle(8);

        // Escapes.
        exp_dv(8'hC0); exp_dv(8'hDB); exp_dv(8'h7E); exp_end(8'd3);
        send(8'hC0); send(8'hDB); send(8'hDC); send(8'hDB); send(8'hDD);
        send(8'h7E); send(8'hC0);
        idle(8);

        // Empty frame is silent.
        exp_dv(8'h05); exp_end(8'd1);
        send(8'hC0); send(8'hC0); send(8'h05); send(8'hC0);
        idle(8);

        // Bad escape: error, hunt, discard 0x10 frame, then 0x22 frame.
        exp_err(); exp_dv(8'h22); exp_end(8'd1);
        send(8'hDB); send(8'h41); send(8'h10); send(8'hC0);
        send(8'h22); send(8'hC0);
        idle(8);

        // Stop bit 0: error, hunt through 33 C0, then 44 frame.
        exp_err();
        send_bits(8'h55, 1'b0);
        idle(60);
        send(8'h33); send(8'hC0);
        exp_dv(8'h44); exp_end(8'd1);
        send(8'h44); send(8'hC0);
        idle(8);

        // Overlong frame with MAX_LEN=3.
        exp_dv(8'h01); exp_dv(8'h02); exp_dv(8'h03); exp_err();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hC0);
        idle(8);

        // One-cycle glitch.
        line = 1'b0;
        @(negedge clk);
        idle(40);

        // Reset mid-frame and mid-byte, line held low after release.
        exp_dv(8'h77);
        send(8'hC0); send(8'h77);
        line = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b1;
        repeat (12) @(negedge clk);
        idle(12);
        exp_dv(8'h55); exp_end(8'd1);
        send(8'hC0); send(8'h55); send(8'hC0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        idle(60);
        check("queue_drained", exp_q.size(), 0);
        check("last_len", int'(o_frame_len), 1);
        check("last_byte", int'(o_rx_byte), 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slip_rx.md
# slip_rx

Host-facing receive stage: a UART receiver (8N1) plus a SLIP decoder that turns the serial command stream from the PC into framed bytes for the transmit-side loop, the counterpart of the SLIP/UART transmitter used on the RX-reporting path. It delivers one decoded byte per strobe, then signals frame completion with the byte count, or a frame error.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per UART bit (10 MHz / 115200). Must be ≥4.
- MAX_LEN, default 127: maximum decoded bytes per frame. Range 1..255.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- i_uart_line  input  1  asynchronous UART RX line, idle high.
- o_rx_dv  output  1  one-cycle strobe: o_rx_byte holds a decoded payload byte.
- o_rx_byte  output  8  decoded byte; holds its value between strobes.
- o_frame_end  output  1  one-cycle strobe: a valid non-empty frame has completed.
- o_frame_len  output  8  payload byte count; valid with o_frame_end, held until the next one.
- o_frame_err  output  1  one-cycle strobe: current frame discarded.

## Operation
- Reset: all outputs 0. Synchronizer flops load 1. UART goes to IDLE and is disarmed. Decoder goes to D_DATA with count 0.
- i_uart_line passes through a 2-flop synchronizer. The UART is armed once the synchronized line reads 1. This avoids misframing after a reset mid-byte.
- UART FSM:
  - IDLE: armed and sync line 0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer divide), re-sample. If 0 -> DATA. If 1 -> IDLE (glitch, no output).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1 -> internal byte strobe. If 0 -> internal framing-error strobe. Either way -> IDLE.
- SLIP decoder, driven by the internal strobes:
  - D_DATA:
    - 0xC0 (END) with count>0: o_frame_end=1, o_frame_len=count, count cleared.
    - 0xC0 with count=0: ignored (empty frames are silent).
    - 0xDB (ESC): -> D_ESC.
    - Other: emit byte.
  - D_ESC:
    - 0xDC: emit 0xC0.
    - 0xDD: emit 0xDB.
    - Other (including 0xC0): o_frame_err, -> D_HUNT.
  - D_HUNT: discard everything until 0xC0, then -> D_DATA with count 0. No o_frame_end.
- Emit: o_rx_dv=1, o_rx_byte=value, count+1. If count is already MAX_LEN: no emit, o_frame_err, -> D_HUNT.
- Framing-error strobe in any decoder state: o_frame_err (suppressed if already in D_HUNT), -> D_HUNT.
- o_rx_dv, o_frame_end and o_frame_err are mutually exclusive in any cycle.

## Timing
- START half-bit check occurs CLKS_PER_BIT/2 cycles after the first synchronized 0.
- Each data sample and the stop sample occur CLKS_PER_BIT cycles after the previous sample.
- The internal byte strobe is registered in the cycle after the stop sample.
- Decoder outputs are registered one cycle after the internal strobe. Total latency from the stop-bit mid-sample to o_rx_dv, o_frame_end or o_frame_err is 2 cycles.
- After the stop sample, IDLE accepts a new start bit on the next cycle. Back-to-back bytes with no idle gap are supported.
- Sustained throughput: one byte per 10·CLKS_PER_BIT cycles. There is no backpressure; the consumer must accept every o_rx_dv.
- Reset asserted mid-byte or mid-frame:
  - Partial data is dropped with no strobes.
  - Reception resumes at the first start bit after the line is seen high.

## Test plan
- CLKS_PER_BIT=4, send C0 01 02 C0 -> o_rx_dv with 0x01, then 0x02; then o_frame_end with o_frame_len=2. No o_frame_err.
- Send C0 DB DC DB DD 7E C0 -> bytes 0xC0, 0xDB, 0x7E; o_frame_len=3.
- Send C0 C0 05 C0 -> single frame, o_frame_len=1. The leading empty frame produces no strobe.
- Send DB 41 then 10 C0 then 22 C0 -> o_frame_err once; the 0x10 frame is discarded; then frame 0x22 with o_frame_len=1.
- Send a byte with stop bit 0, then 33 C0 -> o_frame_err, hunt to END, nothing emitted. Then send 44 C0 -> 0x44, o_frame_len=1.
- Edge cases:
  - MAX_LEN=3, send 01 02 03 04 C0 -> three o_rx_dv, then o_frame_err, no o_frame_end.
  - A 1-cycle low glitch on the line -> no output.
  - Reset pulsed mid-byte, then C0 55 C0 -> clean frame 0x55.
